// File: rtl/registro_casas.sv
//==============================================================================
// Module  : registro_casas
// Purpose : Frogger home-slot occupancy register with full-level hold and auto-clear.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module registro_casas #(
  parameter int DATAWIDTH   = 8,
  parameter int COLWIDTH    = 3,
  parameter int HOLD_CYCLES = 25000000,
  parameter int HOLDWIDTH   = 25
) (
  input  logic                 registro_casas_CLOCK_50,
  input  logic                 registro_casas_RESET_InLow,
  input  logic                 registro_casas_arrive_InHigh,
  input  logic [COLWIDTH-1:0]  registro_casas_column_InBUS,
  input  logic                 registro_casas_clear_InHigh,
  output logic [DATAWIDTH-1:0] registro_casas_data_OutBUS,
  output logic                 registro_casas_newhouse_OutHigh,
  output logic                 registro_casas_collision_OutHigh,
  output logic                 registro_casas_levelup_OutHigh,
  output logic                 registro_casas_busy_OutHigh
);

  localparam logic [0:0]           c_PLAY      = 1'b0;
  localparam logic [0:0]           c_FULL_HOLD = 1'b1;
  localparam logic [HOLDWIDTH-1:0] c_HOLD_LAST = HOLDWIDTH'(HOLD_CYCLES - 1);
  localparam logic [DATAWIDTH-1:0] c_ONE       = DATAWIDTH'(1);
  localparam logic [DATAWIDTH-1:0] c_ALL_ONES  = '1;

  logic [0:0]           r_state;
  logic [0:0]           w_stateNext;
  logic [DATAWIDTH-1:0] r_data;
  logic [DATAWIDTH-1:0] w_dataNext;
  logic [HOLDWIDTH-1:0] r_count;
  logic [HOLDWIDTH-1:0] w_countNext;
  logic                 r_arriveDly;
  logic                 r_newhouse;
  logic                 r_collision;
  logic                 r_levelup;
  logic                 r_busy;
  logic                 w_newhouseNext;
  logic                 w_collisionNext;
  logic                 w_levelupNext;
  logic                 w_busyNext;

  logic                 w_event;
  logic                 w_colValid;
  logic [DATAWIDTH-1:0] w_mask;
  logic                 w_bitSet;
  logic [DATAWIDTH-1:0] w_dataSet;
  logic                 w_holdDone;

  // Delay flop resets high so a frog already in the top row at reset release is not an arrival
  assign w_event    = registro_casas_arrive_InHigh & ~r_arriveDly;
  assign w_colValid = int'({1'b0, registro_casas_column_InBUS}) < DATAWIDTH;
  assign w_mask     = c_ONE << registro_casas_column_InBUS;
  assign w_bitSet   = |(r_data & w_mask);
  assign w_dataSet  = r_data | w_mask;
  assign w_holdDone = (r_count == c_HOLD_LAST);

  always_ff @(posedge registro_casas_CLOCK_50 or negedge registro_casas_RESET_InLow) begin
    if (!registro_casas_RESET_InLow) begin
      r_state <= c_PLAY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if (registro_casas_clear_InHigh) begin
      w_stateNext = c_PLAY;
    end else begin
      case (r_state)
        c_PLAY: begin
          if (w_event && w_colValid && !w_bitSet && (w_dataSet == c_ALL_ONES)) begin
            w_stateNext = c_FULL_HOLD;
          end
        end
        c_FULL_HOLD: begin
          if (w_holdDone) begin
            w_stateNext = c_PLAY;
          end
        end
        default: w_stateNext = c_PLAY;
      endcase
    end
  end

  always_comb begin
    w_dataNext      = r_data;
    w_countNext     = '0;
    w_newhouseNext  = 1'b0;
    w_collisionNext = 1'b0;
    w_levelupNext   = 1'b0;
    if (registro_casas_clear_InHigh) begin
      w_dataNext = '0;
    end else begin
      case (r_state)
        c_PLAY: begin
          if (w_event && w_colValid) begin
            if (w_bitSet) begin
              w_collisionNext = 1'b1;
            end else begin
              w_dataNext     = w_dataSet;
              w_newhouseNext = 1'b1;
            end
          end
        end
        c_FULL_HOLD: begin
          if (w_holdDone) begin
            w_dataNext    = '0;
            w_levelupNext = 1'b1;
          end else begin
            w_countNext = r_count + 1'b1;
          end
        end
        default: w_dataNext = '0;
      endcase
    end
    w_busyNext = (w_stateNext == c_FULL_HOLD);
  end

  always_ff @(posedge registro_casas_CLOCK_50 or negedge registro_casas_RESET_InLow) begin
    if (!registro_casas_RESET_InLow) begin
      r_data      <= '0;
      r_count     <= '0;
      r_arriveDly <= 1'b1;
      r_newhouse  <= 1'b0;
      r_collision <= 1'b0;
      r_levelup   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_data      <= w_dataNext;
      r_count     <= w_countNext;
      r_arriveDly <= registro_casas_arrive_InHigh;
      r_newhouse  <= w_newhouseNext;
      r_collision <= w_collisionNext;
      r_levelup   <= w_levelupNext;
      r_busy      <= w_busyNext;
    end
  end

  assign registro_casas_data_OutBUS       = r_data;
  assign registro_casas_newhouse_OutHigh  = r_newhouse;
  assign registro_casas_collision_OutHigh = r_collision;
  assign registro_casas_levelup_OutHigh   = r_levelup;
  assign registro_casas_busy_OutHigh      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_registro_casas.sv
//==============================================================================
// Module  : tb_registro_casas
// Purpose : Directed scoreboard bench for registro_casas with a short hold interval.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_registro_casas;

  typedef struct packed {
    logic [7:0] data;
    logic       nh;
    logic       co;
    logic       lu;
    logic       bz;
  } obs_t;

  logic       clk;
  logic       rstN;
  logic       arrive;
  logic [2:0] column;
  logic       clear;
  logic [7:0] data;
  logic       newhouse;
  logic       collision;
  logic       levelup;
  logic       busy;

  int errors = 0;
  int checks = 0;

  obs_t  expQ[$];
  string tagQ[$];

  registro_casas #(
    .DATAWIDTH  (8),
    .COLWIDTH   (3),
    .HOLD_CYCLES(4),
    .HOLDWIDTH  (3)
  ) dut (
    .registro_casas_CLOCK_50         (clk),
    .registro_casas_RESET_InLow      (rstN),
    .registro_casas_arrive_InHigh    (arrive),
    .registro_casas_column_InBUS     (column),
    .registro_casas_clear_InHigh     (clear),
    .registro_casas_data_OutBUS      (data),
    .registro_casas_newhouse_OutHigh (newhouse),
    .registro_casas_collision_OutHigh(collision),
    .registro_casas_levelup_OutHigh  (levelup),
    .registro_casas_busy_OutHigh     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(logic [7:0] d, logic nh, logic co, logic lu, logic bz);
    obs_t o;
    o.data = d;
    o.nh   = nh;
    o.co   = co;
    o.lu   = lu;
    o.bz   = bz;
    return o;
  endfunction

  task automatic chk(string tag, obs_t e);
    obs_t o;
    o = mk(data, newhouse, collision, levelup, busy);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed data=%h nh=%b co=%b lu=%b busy=%b expected data=%h nh=%b co=%b lu=%b busy=%b",
             tag, o.data, o.nh, o.co, o.lu, o.bz, e.data, e.nh, e.co, e.lu, e.bz);
    end
  endtask

  task automatic push(string tag, obs_t e);
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  // Advance one clock; outputs are compared on the falling edge, clear of the active edge
  task automatic cycle();
    @(negedge clk);
    if (expQ.size() > 0) begin
      chk(tagQ.pop_front(), expQ.pop_front());
    end
  endtask

  task automatic arrival(string tag, logic [2:0] col, obs_t eHigh, obs_t eLow);
    arrive = 1'b1;
    column = col;
    push({tag, "_hi"}, eHigh);
    cycle();
    arrive = 1'b0;
    push({tag, "_lo"}, eLow);
    cycle();
  endtask

  initial begin
    rstN   = 1'b0;
    arrive = 1'b1;
    column = 3'd0;
    clear  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset", mk(8'h00, 0, 0, 0, 0));
    rstN = 1'b1;

    // Arrive held high across reset release: no event
    for (int i = 0; i < 3; i++) begin
      push("held_arrive", mk(8'h00, 0, 0, 0, 0));
      cycle();
    end
    arrive = 1'b0;
    push("arrive_low", mk(8'h00, 0, 0, 0, 0));
    cycle();

    arrival("first_c3", 3'd3, mk(8'h08, 1, 0, 0, 0), mk(8'h08, 0, 0, 0, 0));
    arrival("coll_c3",  3'd3, mk(8'h08, 0, 1, 0, 0), mk(8'h08, 0, 0, 0, 0));

    // Fill columns 0..7 in order (3 already taken)
    arrival("fill_c0", 3'd0, mk(8'h09, 1, 0, 0, 0), mk(8'h09, 0, 0, 0, 0));
    arrival("fill_c1", 3'd1, mk(8'h0B, 1, 0, 0, 0), mk(8'h0B, 0, 0, 0, 0));
    arrival("fill_c2", 3'd2, mk(8'h0F, 1, 0, 0, 0), mk(8'h0F, 0, 0, 0, 0));
    arrival("fill_c3", 3'd3, mk(8'h0F, 0, 1, 0, 0), mk(8'h0F, 0, 0, 0, 0));
    arrival("fill_c4", 3'd4, mk(8'h1F, 1, 0, 0, 0), mk(8'h1F, 0, 0, 0, 0));
    arrival("fill_c5", 3'd5, mk(8'h3F, 1, 0, 0, 0), mk(8'h3F, 0, 0, 0, 0));
    arrival("fill_c6", 3'd6, mk(8'h7F, 1, 0, 0, 0), mk(8'h7F, 0, 0, 0, 0));
    arrival("fill_c7", 3'd7, mk(8'hFF, 1, 0, 0, 1), mk(8'hFF, 0, 0, 0, 1));
    arrival("hold_arr", 3'd2, mk(8'hFF, 0, 0, 0, 1), mk(8'hFF, 0, 0, 0, 1));
    push("levelup", mk(8'h00, 0, 0, 1, 0));
    cycle();
    push("after_levelup", mk(8'h00, 0, 0, 0, 0));
    cycle();

    // Clear wins over a simultaneous arrival
    arrival("p55_c0", 3'd0, mk(8'h01, 1, 0, 0, 0), mk(8'h01, 0, 0, 0, 0));
    arrival("p55_c2", 3'd2, mk(8'h05, 1, 0, 0, 0), mk(8'h05, 0, 0, 0, 0));
    arrival("p55_c4", 3'd4, mk(8'h15, 1, 0, 0, 0), mk(8'h15, 0, 0, 0, 0));
    arrival("p55_c6", 3'd6, mk(8'h55, 1, 0, 0, 0), mk(8'h55, 0, 0, 0, 0));
    clear  = 1'b1;
    arrive = 1'b1;
    column = 3'd1;
    push("clear_arr", mk(8'h00, 0, 0, 0, 0));
    cycle();
    clear  = 1'b0;
    arrive = 1'b0;
    push("clear_after", mk(8'h00, 0, 0, 0, 0));
    cycle();
    arrival("post_clear_c1", 3'd1, mk(8'h02, 1, 0, 0, 0), mk(8'h02, 0, 0, 0, 0));

    // Refill, then reset in the middle of the hold
    arrival("r_c0", 3'd0, mk(8'h03, 1, 0, 0, 0), mk(8'h03, 0, 0, 0, 0));
    arrival("r_c2", 3'd2, mk(8'h07, 1, 0, 0, 0), mk(8'h07, 0, 0, 0, 0));
    arrival("r_c3", 3'd3, mk(8'h0F, 1, 0, 0, 0), mk(8'h0F, 0, 0, 0, 0));
    arrival("r_c4", 3'd4, mk(8'h1F, 1, 0, 0, 0), mk(8'h1F, 0, 0, 0, 0));
    arrival("r_c5", 3'd5, mk(8'h3F, 1, 0, 0, 0), mk(8'h3F, 0, 0, 0, 0));
    arrival("r_c6", 3'd6, mk(8'h7F, 1, 0, 0, 0), mk(8'h7F, 0, 0, 0, 0));
    arrival("r_c7", 3'd7, mk(8'hFF, 1, 0, 0, 1), mk(8'hFF, 0, 0, 0, 1));
    push("hold_cnt2", mk(8'hFF, 0, 0, 0, 1));
    cycle();
    rstN = 1'b0;
    #1;
    chk("async_reset", mk(8'h00, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      push("in_reset", mk(8'h00, 0, 0, 0, 0));
      cycle();
    end
    rstN = 1'b1;
    push("released", mk(8'h00, 0, 0, 0, 0));
    cycle();
    arrival("post_reset_c5", 3'd5, mk(8'h20, 1, 0, 0, 0), mk(8'h20, 0, 0, 0, 0));

    // Back-to-back arrivals at 2, 2, 5 from an empty register
    clear = 1'b1;
    push("clear2", mk(8'h00, 0, 0, 0, 0));
    cycle();
    clear = 1'b0;
    arrival("b2b_c2a", 3'd2, mk(8'h04, 1, 0, 0, 0), mk(8'h04, 0, 0, 0, 0));
    arrival("b2b_c2b", 3'd2, mk(8'h04, 0, 1, 0, 0), mk(8'h04, 0, 0, 0, 0));
    arrival("b2b_c5",  3'd5, mk(8'h24, 1, 0, 0, 0), mk(8'h24, 0, 0, 0, 0));

    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: observed %0d pending expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
